// File: rtl/bsg_mcl_arb_pkg.sv
// ============================================================================
// Module  : bsg_mcl_arb_pkg
// Brief   : Opcodes, field offsets and packet typedefs shared by the host
//           request arbiter and its round-robin grant logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_mcl_arb_pkg;

  localparam logic [7:0] OP_REMOTE_LOAD  = 8'h00;
  localparam logic [7:0] OP_REMOTE_STORE = 8'h01;

  // Request word field offsets, LSB first
  localparam int REQ_X_LSB       = 0;
  localparam int REQ_Y_LSB       = 8;
  localparam int REQ_SRC_X_LSB   = 16;
  localparam int REQ_SRC_Y_LSB   = 24;
  localparam int REQ_PAYLOAD_LSB = 32;
  localparam int REQ_OP_EX_LSB   = 64;
  localparam int REQ_OP_LSB      = 72;
  localparam int REQ_ADDR_LSB    = 80;
  localparam int REQ_PAD_LSB     = 112;

  // Response word field offsets, LSB first
  localparam int RSP_X_LSB        = 0;
  localparam int RSP_Y_LSB        = 8;
  localparam int RSP_LOAD_ID_LSB  = 16;
  localparam int RSP_DATA_LSB     = 48;
  localparam int RSP_PKT_TYPE_LSB = 80;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int RR_PTR_W        = $clog2(NUM_REQ_DEFAULT);

  function automatic int rr_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [15:0] pad;
    logic [31:0] addr;
    logic [7:0]  op;
    logic [7:0]  op_ex;
    logic [31:0] payload;
    logic [7:0]  src_y;
    logic [7:0]  src_x;
    logic [7:0]  y;
    logic [7:0]  x;
  } bsg_mcl_request_s;

  typedef struct packed {
    logic [39:0] pad;
    logic [7:0]  pkt_type;
    logic [31:0] data;
    logic [31:0] load_id;
    logic [7:0]  y;
    logic [7:0]  x;
  } bsg_mcl_response_s;

endpackage

`default_nettype wire

// File: rtl/bsg_mcl_rr_credit_arb.sv
// ============================================================================
// Module  : bsg_mcl_rr_credit_arb
// Brief   : Rotating-priority grant over an eligibility mask; the pointer
//           moves past the winner on every grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_mcl_rr_credit_arb
  import bsg_mcl_arb_pkg::*;
#(
  parameter int num_req_p = 4,
  parameter int ptr_w_p   = rr_ptr_width(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] eligible_i,
  input  logic                 en_i,
  output logic [num_req_p-1:0] grant_o,
  output logic                 grant_v_o,
  output logic [ptr_w_p-1:0]   grant_idx_o
);

  logic [ptr_w_p-1:0] r_ptr;
  logic [ptr_w_p-1:0] w_cand;
  logic [ptr_w_p-1:0] w_idx;
  logic               w_found;

  // num_req_p is a power of two, so pointer arithmetic wraps naturally
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    for (int k = 0; k < num_req_p; k++) begin
      w_cand = r_ptr + ptr_w_p'(k);
      if (!w_found && eligible_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign grant_v_o   = w_found & en_i;
  assign grant_idx_o = w_idx;
  assign grant_o     = grant_v_o ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_idx)
                                 : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (grant_v_o) begin
      r_ptr <= w_idx + ptr_w_p'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_mcl_host_req_arbiter.sv
// ============================================================================
// Module  : bsg_mcl_host_req_arbiter
// Brief   : Shares one endpoint request FIFO among host requesters with
//           credit-aware round-robin, load tagging and response routing.
//           Optional BSG_MCL_ARB_PERF_EN adds per-requester stall counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_mcl_host_req_arbiter
  import bsg_mcl_arb_pkg::*;
#(
  parameter int num_req_p         = 4,
  parameter int fifo_width_p      = 128,
  parameter int max_out_credits_p = 16,
  parameter int rcv_fifo_els_p    = 32
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p-1:0][fifo_width_p-1:0]    req_data_i,
  output logic [num_req_p-1:0]                      req_ready_o,
  output logic                                      fifo_v_o,
  output logic [fifo_width_p-1:0]                   fifo_data_o,
  input  logic                                      fifo_ready_i,
  input  logic [$clog2(max_out_credits_p+1)-1:0]    out_credits_i,
  input  logic [$clog2(rcv_fifo_els_p+1)-1:0]       rcv_fifo_vacancy_i,
  input  logic                                      rsp_v_i,
  input  logic [fifo_width_p-1:0]                   rsp_data_i,
  output logic                                      rsp_ready_o,
  output logic [num_req_p-1:0]                      rsp_v_o,
  output logic [fifo_width_p-1:0]                   rsp_data_o,
  input  logic [num_req_p-1:0]                      rsp_ready_i,
  output logic [$clog2(max_out_credits_p+1)-1:0]    outstanding_o
`ifdef BSG_MCL_ARB_PERF_EN
  ,
  output logic [num_req_p-1:0][31:0]                stall_cnt_o
`endif
);

  localparam int c_ptr_w  = rr_ptr_width(num_req_p);
  localparam int c_cred_w = $clog2(max_out_credits_p+1);

  logic                                r_fifo_v;
  logic [fifo_width_p-1:0]             r_fifo_data;
  logic                                r_is_load;
  logic [c_ptr_w-1:0]                  r_src;
  logic [c_cred_w-1:0]                 r_outstanding;
  logic [num_req_p-1:0][c_cred_w-1:0]  r_dst_cnt;

  logic [num_req_p-1:0]    w_is_load;
  logic [num_req_p-1:0]    w_eligible;
  logic                    w_load_ok;
  logic                    w_stage_free;
  logic [num_req_p-1:0]    w_grant;
  logic                    w_grant_v;
  logic [c_ptr_w-1:0]      w_grant_idx;
  logic [fifo_width_p-1:0] w_sel_word;
  logic [fifo_width_p-1:0] w_tagged_word;
  logic                    w_out_fire;
  logic                    w_load_leave;
  logic                    w_rsp_fire;
  logic [c_ptr_w-1:0]      w_dst;

  // A load parked in the output stage counts against the budget so the
  // in-flight total can never exceed max_out_credits_p
  assign w_load_ok = (int'(rcv_fifo_vacancy_i) >= max_out_credits_p)
                   & ((int'(r_outstanding) + int'(r_fifo_v & r_is_load))
                      < max_out_credits_p);

  assign w_stage_free = ~r_fifo_v | fifo_ready_i;

  for (genvar i = 0; i < num_req_p; i++) begin : g_req
    assign w_is_load[i]  = (req_data_i[i][REQ_OP_LSB +: 8] == OP_REMOTE_LOAD);
    assign w_eligible[i] = req_v_i[i] & (out_credits_i != '0)
                         & (~w_is_load[i] | w_load_ok);
  end

  bsg_mcl_rr_credit_arb #(
    .num_req_p (num_req_p),
    .ptr_w_p   (c_ptr_w)
  ) u_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .eligible_i  (w_eligible),
    .en_i        (w_stage_free & ~reset_i),
    .grant_o     (w_grant),
    .grant_v_o   (w_grant_v),
    .grant_idx_o (w_grant_idx)
  );

  assign req_ready_o = w_grant;
  assign w_sel_word  = req_data_i[w_grant_idx];

  always_comb begin
    w_tagged_word = w_sel_word;
    if (w_is_load[w_grant_idx]) begin
      w_tagged_word[REQ_PAYLOAD_LSB +: c_ptr_w] = w_grant_idx;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fifo_v    <= 1'b0;
      r_fifo_data <= '0;
      r_is_load   <= 1'b0;
      r_src       <= '0;
    end else if (w_grant_v) begin
      r_fifo_v    <= 1'b1;
      r_fifo_data <= w_tagged_word;
      r_is_load   <= w_is_load[w_grant_idx];
      r_src       <= w_grant_idx;
    end else if (fifo_ready_i) begin
      r_fifo_v    <= 1'b0;
    end
  end

  assign fifo_v_o    = r_fifo_v;
  assign fifo_data_o = r_fifo_data;

  // Response path is a pure pass-through steered by the tag in load_id
  assign w_dst       = rsp_data_i[RSP_LOAD_ID_LSB +: c_ptr_w];
  assign rsp_data_o  = rsp_data_i;
  assign rsp_v_o     = rsp_v_i ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_dst) : '0;
  assign rsp_ready_o = rsp_ready_i[w_dst] & ~reset_i;

  assign w_out_fire   = r_fifo_v & fifo_ready_i;
  assign w_load_leave = w_out_fire & r_is_load;
  assign w_rsp_fire   = rsp_v_i & rsp_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_load_leave, w_rsp_fire})
        2'b10:   r_outstanding <= r_outstanding + c_cred_w'(1);
        2'b01:   r_outstanding <= r_outstanding - c_cred_w'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign outstanding_o = r_outstanding;

  for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
    logic w_inc;
    logic w_dec;
    assign w_inc = w_load_leave & (r_src == c_ptr_w'(i));
    assign w_dec = w_rsp_fire & (w_dst == c_ptr_w'(i));

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_dst_cnt[i] <= '0;
      end else begin
        case ({w_inc, w_dec})
          2'b10:   r_dst_cnt[i] <= r_dst_cnt[i] + c_cred_w'(1);
          2'b01:   r_dst_cnt[i] <= r_dst_cnt[i] - c_cred_w'(1);
          default: r_dst_cnt[i] <= r_dst_cnt[i];
        endcase
      end
    end

`ifndef SYNTHESIS
    a_dst_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(w_dec && !w_inc && r_dst_cnt[i] == '0));
`endif
  end

`ifndef SYNTHESIS
  a_out_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_rsp_fire && !w_load_leave && r_outstanding == '0));
  a_out_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_load_leave && !w_rsp_fire
      && int'(r_outstanding) >= max_out_credits_p));
`endif

`ifdef BSG_MCL_ARB_PERF_EN
  for (genvar i = 0; i < num_req_p; i++) begin : g_perf
    logic [31:0] r_stall;
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_stall <= '0;
      end else if (req_v_i[i] & ~req_ready_o[i]) begin
        r_stall <= r_stall + 32'd1;
      end
    end
    assign stall_cnt_o[i] = r_stall;
  end
`endif

endmodule

`default_nettype wire
